// File: rtl/ocram_dual_port_arbiter.sv
// Round-robin arbiter letting two Avalon-MM requesters share one single-port on-chip RAM.
// After reset it can scrub every RAM word before admitting traffic.
module ocram_dual_port_arbiter #(
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 32,
    parameter bit                SCRUB_EN    = 1'b1,
    parameter logic [DATA_W-1:0] SCRUB_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  init_done,
    input  logic [2*ADDR_W-1:0]   m_address,
    input  logic [1:0]            m_read,
    input  logic [1:0]            m_write,
    input  logic [2*DATA_W/8-1:0] m_byteenable,
    input  logic [2*DATA_W-1:0]   m_writedata,
    output logic [1:0]            m_waitrequest,
    output logic [DATA_W-1:0]     m_readdata,
    output logic [1:0]            m_readdatavalid,
    output logic [ADDR_W-1:0]     ram_address,
    output logic [DATA_W/8-1:0]   ram_byteenable,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic [DATA_W-1:0]     ram_writedata,
    input  logic [DATA_W-1:0]     ram_readdata
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W:0] SCRUB_LAST = {1'b0, {ADDR_W{1'b1}}};

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   scrub_cnt_q, scrub_cnt_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic              init_done_q, init_done_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [ADDR_W-1:0] addr_v [2];
    logic [BE_W-1:0]   be_v   [2];
    logic [DATA_W-1:0] wd_v   [2];
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              g_idx;
    logic              g_rd;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req_slice
            assign addr_v[gi] = m_address[gi*ADDR_W +: ADDR_W];
            assign be_v[gi]   = m_byteenable[gi*BE_W +: BE_W];
            assign wd_v[gi]   = m_writedata[gi*DATA_W +: DATA_W];
            assign req[gi]    = m_read[gi] | m_write[gi];
        end
    endgenerate

    // Grant: lone requester wins, contention resolved by rr_ptr; nothing is granted in reset or scrub.
    always_comb begin
        gnt   = 2'b00;
        g_idx = rr_ptr_q;
        if (!reset && state_q == ST_RUN) begin
            g_idx = (req == 2'b11) ? rr_ptr_q : req[1];
            if (req != 2'b00) begin
                gnt = g_idx ? 2'b10 : 2'b01;
            end
        end
        g_rd = m_read[g_idx] & ~m_write[g_idx];
    end

    always_comb begin
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        ram_address    = addr_q;
        ram_byteenable = be_v[g_idx];
        ram_writedata  = wd_v[g_idx];
        if (!reset && state_q == ST_INIT) begin
            ram_chipselect = 1'b1;
            ram_write      = 1'b1;
            ram_address    = scrub_cnt_q[ADDR_W-1:0];
            ram_byteenable = '1;
            ram_writedata  = SCRUB_VALUE;
        end else if (gnt != 2'b00) begin
            ram_chipselect = 1'b1;
            ram_write      = m_write[g_idx];
            ram_address    = addr_v[g_idx];
        end
    end

    always_comb begin
        state_d     = state_q;
        scrub_cnt_d = scrub_cnt_q;
        init_done_d = init_done_q;
        rr_ptr_d    = rr_ptr_q;
        addr_d      = ram_address;
        rvalid_d    = gnt & {2{g_rd}};
        if (state_q == ST_INIT) begin
            scrub_cnt_d = scrub_cnt_q + 1'b1;
            if (scrub_cnt_q == SCRUB_LAST) begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end
        end
        if (gnt != 2'b00) begin
            rr_ptr_d = ~g_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SCRUB_EN ? ST_INIT : ST_RUN;
            scrub_cnt_q <= '0;
            init_done_q <= ~SCRUB_EN;
            rr_ptr_q    <= 1'b0;
            rvalid_q    <= 2'b00;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            scrub_cnt_q <= scrub_cnt_d;
            init_done_q <= init_done_d;
            rr_ptr_q    <= rr_ptr_d;
            rvalid_q    <= rvalid_d;
            addr_q      <= addr_d;
        end
    end

    // Masking with reset drops a read that completes while reset is already asserted.
    assign m_readdatavalid = reset ? 2'b00 : rvalid_q;
    assign m_readdata      = ram_readdata;
    assign m_waitrequest   = ~gnt;
    assign init_done       = init_done_q;

endmodule
